// File: rtl/fsm_control_mc.sv
// rtl/fsm_control_mc.sv - multi-cycle fetch/decode/execute control FSM for the accumulator datapath
module fsm_control_mc #(
  parameter int OP_W        = 4,
  parameter int MEM_LAT     = 1,
  parameter int HALT_RESUME = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic [OP_W-1:0] ir,
  input  logic            Enter,
  input  logic            out_ready,
  output logic            IRload,
  output logic            JMPmux,
  output logic            PCload,
  output logic            Meminst,
  output logic            MemWr,
  output logic [1:0]      Asel,
  output logic            Aload,
  output logic            Sub,
  output logic            Halt,
  output logic            out_valid,
  output logic            illegal,
  output logic            instr_done
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [15:0] {
    S_START  = 16'h0001,
    S_FETCH  = 16'h0002,
    S_DECODE = 16'h0004,
    S_LOAD   = 16'h0008,
    S_STORE  = 16'h0010,
    S_ADD    = 16'h0020,
    S_SUB    = 16'h0040,
    S_INPUT  = 16'h0080,
    S_JZ     = 16'h0100,
    S_JPOS   = 16'h0200,
    S_HALT   = 16'h0400,
    S_JMP    = 16'h0800,
    S_JNEG   = 16'h1000,
    S_OUTPUT = 16'h2000,
    S_NOP    = 16'h4000,
    S_TRAP   = 16'h8000
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic       upper_bad;

  // Opcode bits above the 4-bit field only exist for wider opcodes; any set bit traps.
  generate
    if (OP_W > 4) begin : g_upper
      assign upper_bad = |ir[OP_W-1:4];
    end else begin : g_no_upper
      assign upper_bad = 1'b0;
    end
  endgenerate

  // State register; reset wins over every transition.
  always_ff @(posedge clock) begin
    if (reset) state <= S_START;
    else       state <= next_state;
  end

  // Wait counter: reload on entry to a memory-stretched state, then count down to the final cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (next_state != state &&
                 (next_state == S_FETCH || next_state == S_LOAD ||
                  next_state == S_ADD   || next_state == S_SUB)) begin
      cnt <= LAT;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Next-state and strobe decode; outputs are forced low while reset is asserted.
  always_comb begin
    next_state = state;
    IRload     = 1'b0;
    JMPmux     = 1'b0;
    PCload     = 1'b0;
    Meminst    = 1'b0;
    MemWr      = 1'b0;
    Asel       = 2'b00;
    Aload      = 1'b0;
    Sub        = 1'b0;
    Halt       = 1'b0;
    out_valid  = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_START: next_state = S_FETCH;
      S_FETCH: begin
        if (cnt == 4'd0) begin
          IRload     = 1'b1;
          PCload     = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        Meminst = 1'b1;
        if (upper_bad) begin
          next_state = S_TRAP;
        end else begin
          case (ir[3:0])
            4'd0:    next_state = S_LOAD;
            4'd1:    next_state = S_STORE;
            4'd2:    next_state = S_ADD;
            4'd3:    next_state = S_SUB;
            4'd4:    next_state = S_INPUT;
            4'd5:    next_state = S_JZ;
            4'd6:    next_state = S_JPOS;
            4'd7:    next_state = S_HALT;
            4'd8:    next_state = S_JMP;
            4'd9:    next_state = S_JNEG;
            4'd10:   next_state = S_OUTPUT;
            4'd11:   next_state = S_NOP;
            default: next_state = S_TRAP;
          endcase
        end
      end
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        if (cnt == 4'd0) begin
          Aload      = 1'b1;
          instr_done = 1'b1;
          next_state = S_START;
        end
      end
      S_ADD, S_SUB: begin
        Meminst = 1'b1;
        Sub     = (state == S_SUB);
        if (cnt == 4'd0) begin
          Aload      = 1'b1;
          instr_done = 1'b1;
          next_state = S_START;
        end
      end
      S_STORE: begin
        Meminst    = 1'b1;
        MemWr      = 1'b1;
        instr_done = 1'b1;
        next_state = S_START;
      end
      S_INPUT: begin
        Asel  = 2'b01;
        Aload = Enter;
        if (Enter) begin
          instr_done = 1'b1;
          next_state = S_START;
        end
      end
      S_JZ, S_JPOS, S_JNEG, S_JMP: begin
        JMPmux     = 1'b1;
        PCload     = (state == S_JMP)  ||
                     (state == S_JZ   && Aeq0) ||
                     (state == S_JPOS && Apos) ||
                     (state == S_JNEG && !Aeq0 && !Apos);
        instr_done = 1'b1;
        next_state = S_START;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          instr_done = 1'b1;
          next_state = S_START;
        end
      end
      S_NOP: begin
        instr_done = 1'b1;
        next_state = S_START;
      end
      S_HALT: begin
        Halt = 1'b1;
        if (HALT_RESUME != 0 && Enter) begin
          instr_done = 1'b1;
          next_state = S_START;
        end
      end
      S_TRAP: begin
        illegal = 1'b1;
        Halt    = 1'b1;
      end
      default: next_state = S_START;
    endcase
    if (reset) begin
      IRload     = 1'b0;
      JMPmux     = 1'b0;
      PCload     = 1'b0;
      Meminst    = 1'b0;
      MemWr      = 1'b0;
      Asel       = 2'b00;
      Aload      = 1'b0;
      Sub        = 1'b0;
      Halt       = 1'b0;
      out_valid  = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_control_mc.sv
// tb/tb_fsm_control_mc.sv - directed bench for fsm_control_mc at MEM_LAT 0 and 3
module tb_fsm_control_mc;

  logic       clock = 1'b0;
  logic       reset, Aeq0, Apos, Enter, out_ready;
  logic [3:0] ir;

  logic       IRload_0, JMPmux_0, PCload_0, Meminst_0, MemWr_0, Aload_0, Sub_0;
  logic       Halt_0, out_valid_0, illegal_0, instr_done_0;
  logic [1:0] Asel_0;
  logic       IRload_3, JMPmux_3, PCload_3, Meminst_3, MemWr_3, Aload_3, Sub_3;
  logic       Halt_3, out_valid_3, illegal_3, instr_done_3;
  logic [1:0] Asel_3;

  // bit order: IRload JMPmux PCload Meminst MemWr Asel[1:0] Aload Sub Halt out_valid illegal instr_done
  logic [12:0] v0, v3;
  assign v0 = {IRload_0, JMPmux_0, PCload_0, Meminst_0, MemWr_0, Asel_0, Aload_0, Sub_0,
               Halt_0, out_valid_0, illegal_0, instr_done_0};
  assign v3 = {IRload_3, JMPmux_3, PCload_3, Meminst_3, MemWr_3, Asel_3, Aload_3, Sub_3,
               Halt_3, out_valid_3, illegal_3, instr_done_3};

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  fsm_control_mc #(.OP_W(4), .MEM_LAT(0), .HALT_RESUME(1)) u0 (
    .clock(clock), .reset(reset), .Aeq0(Aeq0), .Apos(Apos), .ir(ir), .Enter(Enter),
    .out_ready(out_ready), .IRload(IRload_0), .JMPmux(JMPmux_0), .PCload(PCload_0),
    .Meminst(Meminst_0), .MemWr(MemWr_0), .Asel(Asel_0), .Aload(Aload_0), .Sub(Sub_0),
    .Halt(Halt_0), .out_valid(out_valid_0), .illegal(illegal_0), .instr_done(instr_done_0)
  );

  fsm_control_mc #(.OP_W(4), .MEM_LAT(3), .HALT_RESUME(1)) u3 (
    .clock(clock), .reset(reset), .Aeq0(Aeq0), .Apos(Apos), .ir(ir), .Enter(Enter),
    .out_ready(out_ready), .IRload(IRload_3), .JMPmux(JMPmux_3), .PCload(PCload_3),
    .Meminst(Meminst_3), .MemWr(MemWr_3), .Asel(Asel_3), .Aload(Aload_3), .Sub(Sub_3),
    .Halt(Halt_3), .out_valid(out_valid_3), .illegal(illegal_3), .instr_done(instr_done_3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ir = 4'd0; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0; out_ready = 1'b0;
    tick();
    chk("reset_u0", v0, 13'b0);
    chk("reset_u3", v3, 13'b0);
    reset = 1'b0; #1;
    chk("load_start", v0, 13'b0);
    tick(); chk("load_fetch",  v0, 13'b1_0_1_0_0_00_0_0_0_0_0_0);
    tick(); chk("load_decode", v0, 13'b0_0_0_1_0_00_0_0_0_0_0_0);
    tick(); chk("load_exec",   v0, 13'b0_0_0_1_0_10_1_0_0_0_0_1);
    tick(); chk("load_back",   v0, 13'b0);

    ir = 4'b1001;
    tick(); tick(); tick();
    chk("jneg_taken", v0, 13'b0_1_1_0_0_00_0_0_0_0_0_1);
    tick(); Apos = 1'b1;
    tick(); tick(); tick();
    chk("jneg_not_taken", v0, 13'b0_1_0_0_0_00_0_0_0_0_0_1);
    tick(); Apos = 1'b0;

    ir = 4'b0001;
    tick(); tick(); tick();
    chk("store_exec", v0, 13'b0_0_0_1_1_00_0_0_0_0_0_1);
    tick();

    ir = 4'b0100;
    tick(); tick(); tick();
    chk("input_wait", v0, 13'b0_0_0_0_0_01_0_0_0_0_0_0);
    tick();
    chk("input_wait2", v0, 13'b0_0_0_0_0_01_0_0_0_0_0_0);
    Enter = 1'b1; #1;
    chk("input_accept", v0, 13'b0_0_0_0_0_01_1_0_0_0_0_1);
    tick(); Enter = 1'b0; #1;
    chk("input_back", v0, 13'b0);

    ir = 4'b1010; out_ready = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("output_hold", v0, 13'b0_0_0_0_0_00_0_0_0_1_0_0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("output_accept", v0, 13'b0_0_0_0_0_00_0_0_0_1_0_1);
    tick(); out_ready = 1'b0; #1;
    chk("output_back", v0, 13'b0);

    ir = 4'b0111;
    tick(); tick(); tick();
    chk("halt_1", v0, 13'b0_0_0_0_0_00_0_0_1_0_0_0);
    tick(); chk("halt_2", v0, 13'b0_0_0_0_0_00_0_0_1_0_0_0);
    tick(); chk("halt_3", v0, 13'b0_0_0_0_0_00_0_0_1_0_0_0);
    Enter = 1'b1; #1;
    chk("halt_resume", v0, 13'b0_0_0_0_0_00_0_0_1_0_0_1);
    tick(); Enter = 1'b0; #1;
    chk("halt_start", v0, 13'b0);
    tick(); chk("halt_fetch", v0, 13'b1_0_1_0_0_00_0_0_0_0_0_0);

    ir = 4'b1100;
    tick(); tick();
    chk("trap_entry", v0, 13'b0_0_0_0_0_00_0_0_1_0_1_0);
    Enter = 1'b1;
    tick(); chk("trap_sticky_enter", v0, 13'b0_0_0_0_0_00_0_0_1_0_1_0);
    Enter = 1'b0;
    tick(); chk("trap_sticky", v0, 13'b0_0_0_0_0_00_0_0_1_0_1_0);

    reset = 1'b1; ir = 4'b0010;
    tick();
    chk("trap_cleared", v0, 13'b0);
    reset = 1'b0; #1;
    chk("add3_start", v3, 13'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) chk("add3_fetch_wait", v3, 13'b0);
      else       chk("add3_fetch_last", v3, 13'b1_0_1_0_0_00_0_0_0_0_0_0);
    end
    tick(); chk("add3_decode", v3, 13'b0_0_0_1_0_00_0_0_0_0_0_0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) chk("add3_exec_wait", v3, 13'b0_0_0_1_0_00_0_0_0_0_0_0);
      else       chk("add3_exec_last", v3, 13'b0_0_0_1_0_00_1_0_0_0_0_1);
    end
    tick(); chk("add3_back", v3, 13'b0);

    ir = 4'b0000;
    tick(); tick(); tick(); tick();
    tick(); chk("rst3_decode", v3, 13'b0_0_0_1_0_00_0_0_0_0_0_0);
    tick(); chk("rst3_load1",  v3, 13'b0_0_0_1_0_10_0_0_0_0_0_0);
    tick(); reset = 1'b1; #1;
    chk("rst3_load2_reset", v3, 13'b0);
    tick(); reset = 1'b0; #1;
    chk("rst3_start", v3, 13'b0);
    tick(); chk("rst3_fetch_wait", v3, 13'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
